// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: prefetches framebuffer lines into a two-bank line buffer
// and streams them as 12-bit RGB behind the VGA timing generator.
module vga_line_fetcher #(
    parameter int H_DISPLAY       = 640,
    parameter int V_DISPLAY       = 480,
    parameter int V_TOTAL         = 525,
    parameter int HPOS_WIDTH      = 10,
    parameter int VPOS_WIDTH      = 10,
    parameter int ADDR_WIDTH      = 19,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixel_en,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  display_on,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [11:0]           mem_rdata,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  underrun
);

    localparam int XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
    localparam int CW = $clog2(H_DISPLAY + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [HPOS_WIDTH-1:0] LP_HD = HPOS_WIDTH'(H_DISPLAY);
    localparam logic [VPOS_WIDTH:0]   LP_VT = (VPOS_WIDTH+1)'(V_TOTAL);
    localparam logic [VPOS_WIDTH-1:0] LP_VD = VPOS_WIDTH'(V_DISPLAY);
    localparam logic [CW-1:0]         LP_HC = CW'(H_DISPLAY);
    localparam logic [CW-1:0]         LP_HL = CW'(H_DISPLAY - 1);
    localparam logic [OW-1:0]         LP_MO = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                         r_state;
    logic [1:0]                     r_valid;
    logic [1:0][VPOS_WIDTH-1:0]     r_tag;
    logic [VPOS_WIDTH-1:0]          r_cur;
    logic [VPOS_WIDTH-1:0]          r_pend;
    logic                           r_pend_ok;
    logic                           r_req;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [CW-1:0]                  r_issued;
    logic [CW-1:0]                  r_rcvd;
    logic [OW-1:0]                  r_outst;
    logic                           r_ur;
    logic [11:0]                    r_bank0 [H_DISPLAY];
    logic [11:0]                    r_bank1 [H_DISPLAY];
    logic [11:0]                    r_s1_pix;
    logic                           r_s1_hs, r_s1_vs, r_s1_de, r_s1_ok;
    logic                           r_line_ok;
    logic                           r_hs, r_vs;
    logic [11:0]                    r_rgb;

    logic [VPOS_WIDTH:0]            w_sum;
    logic [VPOS_WIDTH-1:0]          w_tgt;
    logic [VPOS_WIDTH-1:0]          w_sline;
    logic                           w_tok, w_trig, w_acc, w_rsp, w_done;
    logic                           w_start, w_abort, w_lstart, w_ok_now;
    logic [ADDR_WIDTH-1:0]          w_base;
    logic [CW-1:0]                  w_iss_nx;
    logic [OW-1:0]                  w_out_nx;
    logic [XW-1:0]                  w_rx, w_wx;

    assign w_sum    = {1'b0, vpos} + (VPOS_WIDTH+1)'(2);
    assign w_tgt    = (w_sum >= LP_VT) ? VPOS_WIDTH'(w_sum - LP_VT)
                                       : w_sum[VPOS_WIDTH-1:0];
    assign w_tok    = w_tgt < LP_VD;
    assign w_trig   = pixel_en && (hpos == LP_HD);
    assign w_acc    = r_req && mem_ready;
    assign w_rsp    = mem_rvalid && (r_outst != '0);
    assign w_done   = (r_state == S_FETCH) && w_rsp && (r_rcvd == LP_HL);
    assign w_iss_nx = r_issued + CW'(w_acc);
    assign w_out_nx = r_outst + OW'(w_acc) - OW'(w_rsp);
    assign w_abort  = w_trig && (((r_state == S_FETCH) && !w_done)
                                 || (r_state == S_DRAIN));
    assign w_lstart = pixel_en && display_on && (hpos == '0);
    assign w_ok_now = r_valid[vpos[0]] && (r_tag[vpos[0]] == vpos);
    assign w_base   = ADDR_WIDTH'(w_sline) * ADDR_WIDTH'(H_DISPLAY);
    assign w_rx     = (hpos < LP_HD) ? XW'(hpos) : '0;
    assign w_wx     = r_rcvd[XW-1:0];

    // A drain that finishes on the same cycle as a trigger starts the newer target.
    always_comb begin
        w_start = 1'b0;
        w_sline = w_tgt;
        unique case (r_state)
            S_IDLE:  w_start = w_trig && w_tok;
            S_FETCH: w_start = w_done && w_trig && w_tok;
            S_DRAIN: begin
                if (r_outst == '0) begin
                    w_start = w_trig ? w_tok : r_pend_ok;
                    w_sline = w_trig ? w_tgt : r_pend;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_rsp && (r_state == S_FETCH)) begin
            if (r_cur[0]) r_bank1[w_wx] <= mem_rdata;
            else          r_bank0[w_wx] <= mem_rdata;
        end
        if (pixel_en)
            r_s1_pix <= vpos[0] ? r_bank1[w_rx] : r_bank0[w_rx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_tag     <= '0;
            r_cur     <= '0;
            r_pend    <= '0;
            r_pend_ok <= 1'b0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_issued  <= '0;
            r_rcvd    <= '0;
            r_outst   <= '0;
            r_ur      <= 1'b0;
            r_line_ok <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_de   <= 1'b0;
            r_s1_ok   <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_rgb     <= '0;
        end else begin
            r_outst <= w_out_nx;
            r_ur    <= w_abort || (w_lstart && !w_ok_now);
            if (w_acc) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= w_iss_nx;
            end
            if (w_rsp && (r_state == S_FETCH))
                r_rcvd <= r_rcvd + 1'b1;
            if (r_state == S_FETCH)
                r_req <= (w_iss_nx < LP_HC) && (w_out_nx < LP_MO);
            unique case (r_state)
                S_IDLE: ;
                S_FETCH: begin
                    if (w_done) begin
                        r_valid[r_cur[0]] <= 1'b1;
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (w_trig) begin
                        r_state   <= S_DRAIN;
                        r_req     <= 1'b0;
                        r_pend    <= w_tgt;
                        r_pend_ok <= w_tok;
                    end
                end
                S_DRAIN: begin
                    if (w_trig) begin
                        r_pend    <= w_tgt;
                        r_pend_ok <= w_tok;
                    end
                    if (r_outst == '0) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_start) begin
                r_valid[w_sline[0]] <= 1'b0;
                r_tag[w_sline[0]]   <= w_sline;
                r_cur    <= w_sline;
                r_addr   <= w_base;
                r_issued <= '0;
                r_rcvd   <= '0;
                r_req    <= 1'b1;
                r_state  <= S_FETCH;
            end
            if (pixel_en) begin
                r_s1_hs <= hsync;
                r_s1_vs <= vsync;
                r_s1_de <= display_on;
                r_s1_ok <= w_lstart ? w_ok_now : r_line_ok;
                if (w_lstart) r_line_ok <= w_ok_now;
                r_hs  <= r_s1_hs;
                r_vs  <= r_s1_vs;
                r_rgb <= (r_s1_de && r_s1_ok) ? r_s1_pix : 12'h000;
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign vga_hsync = r_hs;
    assign vga_vsync = r_vs;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign underrun  = r_ur;

endmodule
